// File: rtl/maxnet_window_competitor_pkg.sv
// Shared types and width helpers for the MaxNet window competitor.
// No logic here; only the FSM state enum, default inhibition shift and width functions.
// Widths are clamped to at least one bit so degenerate parameters still elaborate.
package maxnet_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } mn_state_t;

    localparam int DEFAULT_EPS_SHIFT = 3;

    // Width of the row-major winner index for a KxK window.
    function automatic int idx_width(input int k);
        return ($clog2(k * k) < 1) ? 1 : $clog2(k * k);
    endfunction

    // Width of the iteration counter, able to hold MAX_ITER itself.
    function automatic int iter_width(input int max_iter);
        return ($clog2(max_iter + 1) < 1) ? 1 : $clog2(max_iter + 1);
    endfunction

endpackage

// File: rtl/maxnet_window_competitor_lane.sv
// One MaxNet lane: nxt = max(0, act - ((sum - act) >> EPS_SHIFT)).
// Purely combinational, zero latency.
// No handshake; the parent decides when the result is stored.
module maxnet_update_lane #(
    parameter int EPS_SHIFT = 3
) (
    input  logic [7:0]  act_k,
    input  logic [15:0] sum,
    output logic [7:0]  nxt_k
);

    logic [15:0]        others;
    logic [15:0]        inhib;
    logic signed [16:0] diff;

    assign others = sum - 16'(act_k);
    assign inhib  = others >> EPS_SHIFT;
    assign diff   = $signed({9'b0, act_k}) - $signed({1'b0, inhib});

    // Clamp negative results to zero; a positive result never exceeds act_k.
    always_comb begin
        nxt_k = 8'd0;
        if (!diff[16]) begin
            nxt_k = diff[7:0];
        end
    end

endmodule

// File: rtl/maxnet_window_competitor.sv
// Iterative MaxNet competition over one KxK window; returns winner index and original value.
// Latency: n+2 cycles from acceptance to out_valid, where n is the iteration count (max MAX_ITER+2).
// One window in flight: in_ready only in IDLE; the result is held in DONE until out_ready.
module maxnet_window_competitor
    import maxnet_pkg::*;
#(
    parameter int K         = 3,
    parameter int EPS_SHIFT = DEFAULT_EPS_SHIFT,
    parameter int MAX_ITER  = 32,
    parameter int IDX_W     = idx_width(K),
    parameter int IDX_IT    = iter_width(MAX_ITER)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [0:K-1][0:K-1][7:0]      in_win,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IDX_W-1:0]              out_idx,
    output logic [7:0]                    out_max,
    output logic [IDX_IT-1:0]             out_iters
);

    localparam int N     = K * K;
    localparam int CNT_W = $clog2(N + 1);

    mn_state_t            state;
    logic [0:N-1][7:0]    orig;
    logic [0:N-1][7:0]    act;
    logic [0:N-1][7:0]    nxt;
    logic [IDX_IT-1:0]    iter_cnt;
    logic [15:0]          sum;
    logic [CNT_W-1:0]     nz_cnt;
    logic [IDX_W-1:0]     win_idx;
    logic                 stop;

    assign in_ready = (state == IDLE);

    // One update lane per window element, all sharing the window sum.
    for (genvar k = 0; k < N; k++) begin : g_lane
        maxnet_update_lane #(.EPS_SHIFT(EPS_SHIFT)) u_lane (
            .act_k (act[k]),
            .sum   (sum),
            .nxt_k (nxt[k])
        );
    end

    // Window sum, survivor count and lowest-index nonzero winner.
    always_comb begin
        sum     = 16'd0;
        nz_cnt  = '0;
        win_idx = '0;
        for (int k = 0; k < N; k++) begin
            sum = sum + 16'(act[k]);
            if (act[k] != 8'd0) begin
                nz_cnt = nz_cnt + CNT_W'(1);
            end
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (act[k] != 8'd0) begin
                win_idx = IDX_W'(k);
            end
        end
    end

    // Stop when at most one survivor, the update would clear everything, or the cap is hit.
    assign stop = (nz_cnt <= CNT_W'(1)) || (nxt == '0) || (iter_cnt == IDX_IT'(MAX_ITER));

    // Control FSM, activation registers and registered result.
    // DONE spends its first cycle raising out_valid so the result appears n+2 cycles after acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_max   <= 8'd0;
            out_iters <= '0;
            orig      <= '0;
            act       <= '0;
            iter_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int r = 0; r < K; r++) begin
                            for (int c = 0; c < K; c++) begin
                                orig[r*K+c] <= in_win[r][c];
                                act[r*K+c]  <= in_win[r][c];
                            end
                        end
                        iter_cnt <= '0;
                        state    <= ITER;
                    end
                end
                ITER: begin
                    if (stop) begin
                        out_idx   <= win_idx;
                        out_max   <= orig[win_idx];
                        out_iters <= iter_cnt;
                        state     <= DONE;
                    end else begin
                        act      <= nxt;
                        iter_cnt <= iter_cnt + IDX_IT'(1);
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_window_competitor.sv
// Self-checking bench: directed corner windows plus random windows against a behavioural MaxNet model.
// Checks latency, winner, original value, iteration count, backpressure hold and mid-run reset.
module tb_maxnet_window_competitor;

    localparam int K        = 3;
    localparam int N        = K * K;
    localparam int EPS      = 3;
    localparam int MAX_ITER = 32;

    typedef logic [0:K-1][0:K-1][7:0] win_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    win_t        in_win = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_idx;
    logic [7:0]  out_max;
    logic [5:0]  out_iters;

    int n_checks = 0;
    int n_pass   = 0;

    maxnet_window_competitor #(.K(K), .EPS_SHIFT(EPS), .MAX_ITER(MAX_ITER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_win    (in_win),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_max   (out_max),
        .out_iters (out_iters)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // MaxNet defined directly from its rules on plain integers.
    function automatic void model(input win_t w, output int idx, output int mx, output int it);
        int a[N];
        int nx[N];
        int s, nz;
        bit allz;
        for (int k = 0; k < N; k++) a[k] = int'(w[k/K][k%K]);
        it = 0;
        for (int guard = 0; guard <= MAX_ITER + 1; guard++) begin
            s = 0; nz = 0; allz = 1'b1;
            for (int k = 0; k < N; k++) begin
                s += a[k];
                if (a[k] != 0) nz++;
            end
            for (int k = 0; k < N; k++) begin
                nx[k] = a[k] - ((s - a[k]) / (1 << EPS));
                if (nx[k] < 0) nx[k] = 0;
                if (nx[k] != 0) allz = 1'b0;
            end
            if (nz <= 1 || allz || it == MAX_ITER) break;
            a = nx;
            it++;
        end
        idx = 0;
        for (int k = N - 1; k >= 0; k--) if (a[k] != 0) idx = k;
        mx = int'(w[idx/K][idx%K]);
    endfunction

    // Push one window, check latency and result, hold the result for `hold` cycles, then consume it.
    task automatic run_win(input string tag, input win_t w, input int hold, input bit poke);
        int eidx, emax, eit, lat;
        model(w, eidx, emax, eit);
        @(negedge clk);
        in_win   = w;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < MAX_ITER + 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, eit + 2);
        chk({tag, "_idx"}, int'(out_idx), eidx);
        chk({tag, "_max"}, int'(out_max), emax);
        chk({tag, "_iters"}, int'(out_iters), eit);
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                in_valid = 1'b1;
                in_win   = ~w;
            end
            @(posedge clk); #1;
            chk({tag, "_hold_vld"}, int'(out_valid), 1);
            chk({tag, "_hold_rdy"}, int'(in_ready), 0);
            chk({tag, "_hold_idx"}, int'(out_idx), eidx);
            chk({tag, "_hold_max"}, int'(out_max), emax);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_drain_vld"}, int'(out_valid), 0);
        chk({tag, "_drain_rdy"}, int'(in_ready), 1);
    endtask

    function automatic win_t from_list(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
        win_t w;
        int v[N];
        v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
        for (int k = 0; k < N; k++) w[k/K][k%K] = 8'(v[k]);
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        win_t w;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_max", int'(out_max), 0);
        chk("rst_out_iters", int'(out_iters), 0);
        rst_n = 1'b1;

        // Directed corners with hand-derived expectations.
        w = from_list(10, 20, 30, 40, 90, 50, 60, 70, 80);
        run_win("distinct", w, 0, 1'b0);
        chk("distinct_hand_idx", int'(out_idx), 4);
        chk("distinct_hand_max", int'(out_max), 90);

        w = '0;
        run_win("zero", w, 0, 1'b0);
        chk("zero_hand_iters", int'(out_iters), 0);

        w = from_list(0, 0, 0, 0, 0, 0, 0, 0, 5);
        run_win("single", w, 0, 1'b0);
        chk("single_hand_idx", int'(out_idx), 8);
        chk("single_hand_iters", int'(out_iters), 0);

        w = from_list(0, 0, 200, 0, 0, 0, 200, 0, 0);
        run_win("tie", w, 0, 1'b0);
        chk("tie_hand_iters", int'(out_iters), 32);
        chk("tie_hand_idx", int'(out_idx), 2);
        chk("tie_hand_max", int'(out_max), 200);

        // Backpressure with a competing input that must be ignored.
        w = from_list(10, 20, 30, 40, 90, 50, 60, 70, 80);
        run_win("bp", w, 5, 1'b1);
        w = from_list(0, 0, 0, 0, 0, 0, 0, 0, 5);
        run_win("after_bp", w, 0, 1'b0);

        // Reset in the middle of a capped run.
        w = from_list(0, 0, 200, 0, 0, 0, 200, 0, 0);
        @(negedge clk);
        in_win = w;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_busy", int'(in_ready), 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_idx", int'(out_idx), 0);
        chk("midrst_out_max", int'(out_max), 0);
        chk("midrst_out_iters", int'(out_iters), 0);
        w = from_list(3, 9, 1, 7, 2, 8, 0, 4, 6);
        run_win("post_rst", w, 0, 1'b0);

        // Random windows with varying sparsity and backpressure.
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 2) == 0) w[k/K][k%K] = 8'd0;
                else w[k/K][k%K] = 8'($urandom_range(0, 255));
            end
            run_win($sformatf("rnd%0d", t), w, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/maxnet_window_competitor.md
# maxnet_window_competitor

Iterative MaxNet competition stage that sits directly downstream of `window_selector_KxK`. It accepts one K×K window of unsigned 8-bit activations over a valid/ready handshake. It runs MaxNet lateral-inhibition iterations until at most one activation survives, then returns the winner's row-major index and its original value. Its output feeds the pooling/result collector.

## Interface
- `K`, default 3: window side; the window holds N = K*K elements.
- `EPS_SHIFT`, default 3: inhibition weight ε = 2^-EPS_SHIFT.
- `MAX_ITER`, default 32: iteration cap; must be ≥ 1.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `in_valid`  in  1: `in_win` is valid.
- `in_ready`  out  1: block can accept a window.
- `in_win`  in  [7:0] [0:K-1][0:K-1]: window from `window_selector_KxK`.
- `out_valid`  out  1: result is valid.
- `out_ready`  in  1: consumer takes the result.
- `out_idx`  out  IDX_W = $clog2(N): winner index, r*K+c.
- `out_max`  out  8: original (pre-iteration) value at `out_idx`.
- `out_iters`  out  IDX_IT = $clog2(MAX_ITER+1): iterations performed.

## Operation
- States are IDLE, ITER and DONE.
- Reset:
  - state = IDLE.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_idx`, `out_max` and `out_iters` = 0.
  - All activation registers = 0.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`, capture `in_win` into `orig[]` and `act[]`, clear `iter_cnt`, and go to ITER.
- ITER: `in_ready` = 0. Each cycle computes:
  - S = Σ act[k], an unsigned 16-bit sum with no overflow.
  - nxt[k] = act[k] − ((S − act[k]) >> EPS_SHIFT), clamped to 0 if negative. The subtraction is done in signed 17-bit, then clamped and truncated to 8 bits.
- ITER terminates, without updating `act`, if any of these holds:
  - (a) the number of nonzero `act[k]` is ≤ 1;
  - (b) every `nxt[k]` = 0;
  - (c) `iter_cnt` == MAX_ITER.
- On termination:
  - winner w = lowest index k with `act[k]` ≠ 0, or 0 if none.
  - Register `out_idx` = w, `out_max` = `orig[w]`, `out_iters` = `iter_cnt`.
  - Go to DONE.
- If ITER does not terminate: `act` <= `nxt` and `iter_cnt` += 1.
- Ties (equal survivors) resolve to the lowest index.
- DONE:
  - `out_valid` = 1.
  - Outputs stay stable while `out_ready` = 0.
  - On `out_ready`, go to IDLE with `out_valid` = 0 next cycle.
  - Output registers keep their last values in IDLE.
- Reset mid-operation: `rst_n` low in any state forces the reset values at the next edge, and the in-flight window is discarded.

## Timing
- Window accepted at edge T, where `in_valid` && `in_ready`.
- The first ITER evaluation happens in the cycle after T.
- With n iterations (`out_iters` = n), `out_valid` rises at edge T + n + 2.
- Minimum latency is 2 cycles (n = 0).
- Maximum latency is MAX_ITER + 2 cycles.
- Next acceptance is possible at the earliest in the cycle after the `out_valid` && `out_ready` handshake: `in_ready` returns 1 one cycle after that handshake.
- There is no combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`. All outputs are registered or decoded from state.

## Structure
- Package `maxnet_pkg` holds:
  - the state enum `mn_state_t` (IDLE, ITER, DONE);
  - `DEFAULT_EPS_SHIFT`;
  - the width helper functions for IDX_W and IDX_IT.
- Sub-module `maxnet_update_lane`: combinational single-element update.
  - Inputs: `act_k` and S.
  - Output: `nxt_k`.
  - Instantiated N times.
- The top module holds the FSM, the `orig`/`act` registers, the sum, the nonzero count, the priority encoder, `iter_cnt` and the output registers.

## Test plan
- Distinct maximum: window [[10,20,30],[40,90,50],[60,70,80]].
  - Required: `out_idx` = 4, `out_max` = 90, `out_iters` ≥ 1.
  - `out_valid` rises exactly `out_iters` + 2 cycles after acceptance.
- All-zero window.
  - Required: `out_idx` = 0, `out_max` = 0, `out_iters` = 0, `out_valid` 2 cycles after acceptance.
- Single nonzero: only element 8 = 5.
  - Required: `out_idx` = 8, `out_max` = 5, `out_iters` = 0.
- Tie: elements 2 and 6 = 200, rest 0 (the survivors settle at 7 and never clear).
  - Required: terminates on the cap with `out_iters` = 32, `out_idx` = 2, `out_max` = 200.
- Backpressure: hold `out_ready` = 0 for 5 cycles in DONE.
  - Required: outputs stable, `in_ready` = 0, a new `in_valid` is ignored.
  - After `out_ready`, the next window is accepted and processed correctly.
- Reset mid-ITER: assert `rst_n` = 0 for 1 cycle during the tie test.
  - Required: next cycle state IDLE, `in_ready` = 1, `out_valid` = 0, outputs 0.
  - A fresh window then completes normally.
